mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between instruction fetch (read only) and the MEM stage (data read/write).
//  Sits between the fetch/memory stages and the backing memory.
//  Arbitrates requests, holds a registered request until the memory acks, and returns data with a one-cycle ready pulse.
//  Generates per-requester stall signals; a starvation guard keeps fetch from being locked out.
// PARAMETERS
//  AW            32   address width
//  DW            32   data width
//  STARVE_LIMIT  4    max consecutive data grants while fetch waits (range 1..15)
//  TIMEOUT       255  max cycles a transfer waits for mem_ack before abort (range 1..255)
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous reset, active low
//  if_req     in   1   fetch read request
//  if_addr    in   AW  fetch address
//  if_rdata   out  DW  fetch read data, valid with if_ready
//  if_ready   out  1   one-cycle pulse: fetch transfer done
//  if_stall   out  1   if_req & ~if_ready (combinational)
//  dm_req     in   1   data request (memread|memwrite)
//  dm_we      in   1   1 = write, 0 = read
//  dm_addr    in   AW  data address
//  dm_wdata   in   DW  write data
//  dm_rdata   out  DW  data read data, valid with dm_ready
//  dm_ready   out  1   one-cycle pulse: data transfer done
//  dm_stall   out  1   dm_req & ~dm_ready (combinational)
//  mem_req    out  1   memory request, held until mem_ack or timeout
//  mem_we     out  1   memory write enable; only for a data write
//  mem_addr   out  AW  latched address
//  mem_wdata  out  DW  latched write data
//  mem_rdata  in   DW  memory read data, valid with mem_ack
//  mem_ack    in   1   memory completion
//  bus_err    out  1   sticky: a transfer timed out
// BEHAVIOUR
//  - Clock and reset: one clock clk; reset rst_n is asynchronous, active low.
//  - Reset values: state IDLE; streak=0; tcnt=0; all outputs 0.
//    An assertion during a transfer drops mem_req immediately; no ready pulse is produced.
//  - FSM: IDLE, IF_XFER, DM_XFER.
//  - IDLE grant at the clock edge, evaluated in this order:
//    1. dm_req & ~(if_req & streak==STARVE_LIMIT) -> DM_XFER
//    2. else if_req -> IF_XFER
//    3. else stay in IDLE
//  - At grant: latch addr/wdata/we into the mem_* registers. mem_we = dm_we only in DM_XFER, else 0.
//  - Request phase: mem_req=1 during XFER states; mem_addr, mem_wdata and mem_we stay stable until the transfer ends.
//  - Completion: when mem_ack=1 in XFER, capture mem_rdata into the owner's rdata register.
//    Pulse the owner's ready for exactly one cycle, drop mem_req and return to IDLE.
//    No grant is made in the cycle the FSM returns to IDLE.
//  - Latency: request seen in cycle N -> mem_req from N+1.
//    With ack in N+1, ready pulses in N+2. Back-to-back throughput is one transfer per 3 cycles minimum.
//  - rdata holds its last captured value between transfers. A write leaves dm_rdata unchanged.
//  - Streak counter, updated on each DM grant:
//    - if_req=1: streak+1, saturating at STARVE_LIMIT.
//    - if_req=0: streak=0.
//    - Any IF grant: streak=0.
//  - Timeout: tcnt counts XFER cycles without ack and clears on entry to XFER.
//    When tcnt==TIMEOUT with no ack: drop mem_req, pulse the owner's ready with rdata={DW/4{4'hD}}, set bus_err, go to IDLE.
//    bus_err clears only on reset. Ack and timeout in the same cycle: ack wins, no error.
//  - Requester drops req mid-transfer: the transfer still completes and the ready pulse still fires; the requester ignores it.
//    Writes are never cancelled.
//  - mem_ack while IDLE is ignored. Inputs are not sampled during XFER; a new request waits for IDLE.
// TESTING
//  1. Reset, then if_req=1, if_addr=0x40, ack 1 cycle after mem_req with mem_rdata=0x8C010004
//     -> mem_req=1/mem_we=0/mem_addr=0x40; if_ready pulses 1 cycle with if_rdata=0x8C010004; if_stall high until then.
//  2. if_req and dm_req both high, dm_we=1, dm_addr=0x100, dm_wdata=0x55
//     -> data first: mem_we=1, mem_addr=0x100, mem_wdata=0x55; dm_ready pulses; fetch granted next.
//  3. dm_req held high for 10 transfers, if_req high, STARVE_LIMIT=4
//     -> order D,D,D,D,I,D,D,D,D,I; streak resets after each I.
//  4. Memory ack delayed 3 cycles -> mem_req and mem_addr stable for 4 cycles; ready exactly 1 cycle after ack.
//  5. No ack, TIMEOUT=8 -> mem_req drops after 8 cycles; if_rdata=0xDDDDDDDD; bus_err=1 and stays 1 until rst_n.
//  6. rst_n pulsed low mid-DM_XFER -> mem_req=0 at once with no clock edge; no dm_ready; IDLE and the next request behaves as in 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and data access
//
// Purpose:
//   Shares one single-port memory between the fetch stage (read only) and the
//   MEM stage (read/write). It grants one requester, holds a registered request
//   until the memory acks or the transfer times out, then returns data with a
//   one-cycle ready pulse. A streak counter limits consecutive data grants
//   while fetch is waiting.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   if_req, if_addr            fetch read request and address
//   if_rdata, if_ready         fetch read data, valid with the one-cycle if_ready pulse
//   if_stall                   if_req & ~if_ready
//   dm_req, dm_we              data request, 1 = write
//   dm_addr, dm_wdata          data address and write data
//   dm_rdata, dm_ready         data read data, valid with the one-cycle dm_ready pulse
//   dm_stall                   dm_req & ~dm_ready
//   mem_req, mem_we            memory request (held until ack/timeout), write enable
//   mem_addr, mem_wdata        latched address and write data
//   mem_rdata, mem_ack         memory read data and completion
//   bus_err                    sticky flag: a transfer timed out

module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          bus_err
);

  localparam logic [DW-1:0] ABORT_DATA = {(DW/4){4'hD}};
  localparam logic [3:0]    STREAK_MAX = 4'(STARVE_LIMIT);
  localparam logic [8:0]    TCNT_LIMIT = 9'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IF_XFER = 2'd1,
    S_DM_XFER = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [3:0]      r_streak;
  logic [7:0]      r_tcnt;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic            r_mem_we;
  logic [DW-1:0]   r_if_rdata;
  logic [DW-1:0]   r_dm_rdata;
  logic            r_if_ready;
  logic            r_dm_ready;
  logic            r_bus_err;

  logic            w_xfer;
  logic            w_block;
  logic            w_starve;
  logic [8:0]      w_tcnt_inc;
  logic            w_timeout;
  logic            w_grant_dm;
  logic            w_grant_if;
  logic            w_done;

  assign w_xfer     = (r_state != S_IDLE);
  // The cycle carrying a ready pulse is the first IDLE cycle after a transfer;
  // no grant is made there, which sets the 3-cycle minimum per transfer.
  assign w_block    = r_if_ready | r_dm_ready;
  assign w_starve   = if_req && (r_streak == STREAK_MAX);
  // r_tcnt holds the number of earlier ack-less XFER cycles, so counting the
  // current one means mem_req is held for exactly TIMEOUT cycles before abort.
  assign w_tcnt_inc = {1'b0, r_tcnt} + 9'd1;
  // An ack in the final cycle wins over the timeout.
  assign w_timeout  = w_xfer && !mem_ack && (w_tcnt_inc == TCNT_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_dm  = 1'b0;
    w_grant_if  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_block) begin
          if (dm_req && !w_starve) begin
            w_state_nxt = S_DM_XFER;
            w_grant_dm  = 1'b1;
          end else if (if_req) begin
            w_state_nxt = S_IF_XFER;
            w_grant_if  = 1'b1;
          end
        end
      end
      S_IF_XFER, S_DM_XFER: begin
        if (mem_ack || w_timeout) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak    <= 4'd0;
      r_tcnt      <= 8'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_ready  <= 1'b0;
      r_dm_ready  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;

      if (w_grant_dm) begin
        r_mem_addr  <= dm_addr;
        r_mem_wdata <= dm_wdata;
        r_mem_we    <= dm_we;
        r_tcnt      <= 8'd0;
        if (!if_req) begin
          r_streak <= 4'd0;
        end else if (r_streak != STREAK_MAX) begin
          r_streak <= r_streak + 4'd1;
        end
      end else if (w_grant_if) begin
        r_mem_addr <= if_addr;
        r_mem_we   <= 1'b0;
        r_tcnt     <= 8'd0;
        r_streak   <= 4'd0;
      end else if (w_xfer && !w_done) begin
        r_tcnt <= r_tcnt + 8'd1;
      end

      if (w_done) begin
        if (!mem_ack) begin
          r_bus_err <= 1'b1;
        end
        if (r_state == S_IF_XFER) begin
          r_if_ready <= 1'b1;
          r_if_rdata <= mem_ack ? mem_rdata : ABORT_DATA;
        end else begin
          r_dm_ready <= 1'b1;
          if (!mem_ack) begin
            r_dm_rdata <= ABORT_DATA;
          end else if (!r_mem_we) begin
            r_dm_rdata <= mem_rdata;
          end
        end
      end
    end
  end

  assign mem_req   = w_xfer;
  assign mem_we    = r_mem_we && (r_state == S_DM_XFER);
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_ready  = r_if_ready;
  assign dm_ready  = r_dm_ready;
  assign if_stall  = if_req & ~r_if_ready;
  assign dm_stall  = dm_req & ~r_dm_ready;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

  localparam int STARVE = 4;
  localparam int TOUT   = 8;
  localparam logic [31:0] ABORT = 32'hDDDD_DDDD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, if_stall, dm_ready, dm_stall, mem_req, mem_we, bus_err;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(STARVE), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: starvation streak, sticky error, last data returned
  int          m_streak;
  bit          m_berr;
  logic [31:0] m_if_rdata, m_dm_rdata;
  int          grant_wait;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_streak   = 0;
    m_berr     = 1'b0;
    m_if_rdata = '0;
    m_dm_rdata = '0;
    grant_wait = 1;
  endtask

  task automatic rand_reqs();
    if_req   = ($urandom_range(0, 9) < 7);
    dm_req   = ($urandom_range(0, 9) < 8);
    if (!if_req && !dm_req) if_req = 1'b1;
    dm_we    = $urandom_range(0, 1) == 1;
    if_addr  = $urandom;
    dm_addr  = $urandom;
    dm_wdata = $urandom;
  endtask

  // force_d: -1 random ack delay, -2 no ack (timeout), >=0 fixed delay
  task automatic do_xfer(input int force_d, input bit use_rd, input logic [31:0] force_rd);
    bit          exp_dm, exp_we, tmo;
    logic [31:0] exp_addr, exp_wd, rd;
    int          d;
    exp_dm   = dm_req && !(if_req && m_streak == STARVE);
    exp_we   = exp_dm && dm_we;
    exp_addr = exp_dm ? dm_addr : if_addr;
    exp_wd   = dm_wdata;
    if (exp_dm) m_streak = if_req ? ((m_streak + 1 > STARVE) ? STARVE : m_streak + 1) : 0;
    else        m_streak = 0;

    for (int i = 1; i <= grant_wait; i++) begin
      @(negedge clk);
      if (i == 1) chk("ready_one_cycle", {if_ready, dm_ready}, 2'b00);
      if (i < grant_wait) chk("no_grant_after_done", mem_req, 1'b0);
    end
    chk("grant_req", mem_req, 1'b1);
    chk("grant_addr", mem_addr, exp_addr);
    chk("grant_we", mem_we, exp_we);
    if (exp_we) chk("grant_wdata", mem_wdata, exp_wd);
    chk("xfer_stall", {if_stall, dm_stall}, {if_req, dm_req});

    // Requesters may change or drop inputs while the transfer runs
    if ($urandom_range(0, 3) == 0) begin
      if_req = $urandom_range(0, 1) == 1; dm_req = $urandom_range(0, 1) == 1;
      dm_we = $urandom_range(0, 1) == 1; if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
    end

    if (force_d == -2)      tmo = 1'b1;
    else if (force_d >= 0)  tmo = 1'b0;
    else                    tmo = ($urandom_range(0, 7) == 0);
    if (force_d >= 0)                   d = force_d;
    else if ($urandom_range(0, 5) == 0) d = TOUT - 1;
    else                                d = $urandom_range(0, 3);
    rd = use_rd ? force_rd : $urandom;

    if (tmo) begin
      for (int i = 1; i < TOUT; i++) begin
        @(negedge clk);
        chk("tmo_hold_req", mem_req, 1'b1);
        chk("tmo_hold_addr", mem_addr, exp_addr);
      end
    end else begin
      for (int i = 0; i < d; i++) begin
        @(negedge clk);
        chk("wait_hold_req", mem_req, 1'b1);
        chk("wait_hold_addr", mem_addr, exp_addr);
        chk("wait_hold_we", mem_we, exp_we);
      end
      mem_rdata = rd;
      mem_ack   = 1'b1;
    end
    @(negedge clk);
    mem_ack = 1'b0;

    if (tmo) begin
      m_berr = 1'b1;
      if (exp_dm) m_dm_rdata = ABORT; else m_if_rdata = ABORT;
    end else if (exp_dm) begin
      if (!exp_we) m_dm_rdata = rd;
    end else begin
      m_if_rdata = rd;
    end

    chk("done_if_ready", if_ready, !exp_dm);
    chk("done_dm_ready", dm_ready, exp_dm);
    chk("done_if_rdata", if_rdata, m_if_rdata);
    chk("done_dm_rdata", dm_rdata, m_dm_rdata);
    chk("done_bus_err", bus_err, m_berr);
    chk("done_mem_req", mem_req, 1'b0);
    chk("done_if_stall", if_stall, if_req && exp_dm);
    chk("done_dm_stall", dm_stall, dm_req && !exp_dm);
    grant_wait = 2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst_n = 1'b0; if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    model_reset();
    #12;
    chk("rst_outputs", {mem_req, mem_we, if_ready, dm_ready, bus_err, if_stall, dm_stall}, 7'd0);
    chk("rst_data", {if_rdata, dm_rdata}, 64'd0);
    chk("rst_mem", {mem_addr, mem_wdata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic fetch read
    if_req = 1; if_addr = 32'h40; dm_req = 0;
    do_xfer(0, 1'b1, 32'h8C01_0004);

    // Simultaneous requests: data write wins, fetch follows
    if_req = 1; dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'h55; if_addr = 32'h44;
    do_xfer(0, 1'b0, 32'h0);
    if_req = 1; dm_req = 0;
    do_xfer(-1, 1'b0, 32'h0);

    // Sustained contention exercises the starvation guard
    for (int n = 0; n < 10; n++) begin
      if_req = 1; dm_req = 1; dm_we = $urandom_range(0, 1) == 1;
      if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
      do_xfer(-1, 1'b0, 32'h0);
    end

    // Delayed ack, then a timeout with sticky error
    if_req = 1; dm_req = 0; if_addr = 32'h80;
    do_xfer(3, 1'b0, 32'h0);
    if_req = 1; dm_req = 0; if_addr = 32'h84;
    do_xfer(-2, 1'b0, 32'h0);

    // Randomized traffic with idle gaps and stray acks while idle
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        if_req = 0; dm_req = 0;
        g = $urandom_range(1, 3);
        for (int i = 0; i < g; i++) begin
          mem_ack = $urandom_range(0, 1) == 1;
          mem_rdata = $urandom;
          @(negedge clk);
          chk("idle_no_req", mem_req, 1'b0);
        end
        mem_ack = 0;
        grant_wait = 1;
      end
      rand_reqs();
      do_xfer(-1, 1'b0, 32'h0);
    end

    // Reset mid data transfer
    if_req = 0; dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'h1234;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_req", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", mem_req, 1'b0);
    chk("async_rst_flags", {dm_ready, bus_err, mem_we}, 3'd0);
    @(negedge clk);
    chk("rst_no_ready", {if_ready, dm_ready}, 2'b00);
    model_reset();
    dm_req = 0;
    rst_n = 1'b1;
    if_req = 1; if_addr = 32'h40;
    do_xfer(0, 1'b1, 32'h8C01_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
